// File: rtl/branch_cmp_pipe.sv
// Two-stage branch comparator with valid/ready handshake, flush and async reset.
// Optional statistics counters (total_cnt/taken_cnt) are built when CMP_STATS_EN is defined.
module branch_cmp_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] rd1,
   input  logic [WIDTH-1:0] rd2,
   input  logic [2:0]       cmp_op,
   input  logic [TAG_W-1:0] tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [TAG_W-1:0] out_tag
`ifdef CMP_STATS_EN
   ,
   output logic [CNT_W-1:0] total_cnt,
   output logic [CNT_W-1:0] taken_cnt
`endif
);

   // Ops 010..101 look only at rd1; signed forms treat the MSB as the sign bit.
   function automatic logic cmp_taken_f(input logic [2:0] op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
      logic res_v;
      case (op)
         3'b000:  res_v = (a == b);
         3'b001:  res_v = (a != b);
         3'b010:  res_v = a[WIDTH-1] || (a == {WIDTH{1'b0}});
         3'b011:  res_v = !a[WIDTH-1] && (a != {WIDTH{1'b0}});
         3'b100:  res_v = a[WIDTH-1];
         3'b101:  res_v = !a[WIDTH-1];
         3'b110:  res_v = ($signed(a) < $signed(b));
         3'b111:  res_v = (a < b);
         default: res_v = 1'b0;
      endcase
      return res_v;
   endfunction

   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_rd1_r;
   logic [WIDTH-1:0] s1_rd2_r;
   logic [2:0]       s1_op_r;
   logic [TAG_W-1:0] s1_tag_r;
   logic             s2_valid_r;
   logic             s2_taken_r;
   logic [TAG_W-1:0] s2_tag_r;

   logic s2_adv_s;
   logic s1_load_s;
   logic s1_taken_s;

   // Handshake decode: S2 can take S1 when empty or when its result is leaving.
   always_comb begin
      s2_adv_s   = 1'b0;
      s1_load_s  = 1'b0;
      in_ready   = 1'b0;
      s1_taken_s = 1'b0;
      if (s1_valid_r) begin
         s2_adv_s = !s2_valid_r || out_ready;
      end else begin
         s2_adv_s = 1'b0;
      end
      in_ready   = !s1_valid_r || s2_adv_s;
      s1_load_s  = in_valid && in_ready;
      s1_taken_s = cmp_taken_f(s1_op_r, s1_rd1_r, s1_rd2_r);
   end

   // Stage valid bits; flush beats every load, including the one accepted this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s2_valid_r <= 1'b0;
      end else if (flush) begin
         s1_valid_r <= 1'b0;
         s2_valid_r <= 1'b0;
      end else begin
         if (s1_load_s) begin
            s1_valid_r <= 1'b1;
         end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
         end
         if (s2_adv_s) begin
            s2_valid_r <= 1'b1;
         end else if (out_ready) begin
            s2_valid_r <= 1'b0;
         end
      end
   end

   // Stage 1 operand capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_rd1_r <= {WIDTH{1'b0}};
         s1_rd2_r <= {WIDTH{1'b0}};
         s1_op_r  <= 3'b000;
         s1_tag_r <= {TAG_W{1'b0}};
      end else if (s1_load_s) begin
         s1_rd1_r <= rd1;
         s1_rd2_r <= rd2;
         s1_op_r  <= cmp_op;
         s1_tag_r <= tag;
      end
   end

   // Stage 2 result; holds while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_taken_r <= 1'b0;
         s2_tag_r   <= {TAG_W{1'b0}};
      end else if (s2_adv_s) begin
         s2_taken_r <= s1_taken_s;
         s2_tag_r   <= s1_tag_r;
      end
   end

   assign out_valid = s2_valid_r;
   assign out_taken = s2_taken_r;
   assign out_tag   = s2_tag_r;

`ifdef CMP_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] cnt);
      logic [CNT_W-1:0] res_v;
      if (cnt == {CNT_W{1'b1}}) begin
         res_v = cnt;
      end else begin
         res_v = cnt + CNT_ONE;
      end
      return res_v;
   endfunction

   logic [CNT_W-1:0] total_cnt_r;
   logic [CNT_W-1:0] taken_cnt_r;

   // Consumption statistics; only reset clears them, flush leaves them alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_cnt_r <= {CNT_W{1'b0}};
         taken_cnt_r <= {CNT_W{1'b0}};
      end else if (s2_valid_r && out_ready) begin
         total_cnt_r <= sat_inc_f(total_cnt_r);
         if (s2_taken_r) begin
            taken_cnt_r <= sat_inc_f(taken_cnt_r);
         end
      end
   end

   assign total_cnt = total_cnt_r;
   assign taken_cnt = taken_cnt_r;
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Directed testbench for branch_cmp_pipe; statistics checks run when CMP_STATS_EN is defined.
module tb_branch_cmp_pipe;
   localparam int WIDTH = 32;
   localparam int TAG_W = 5;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic [2:0]       cmp_op;
   logic [TAG_W-1:0] tag;
   logic             out_valid;
   logic             out_ready;
   logic             out_taken;
   logic [TAG_W-1:0] out_tag;
`ifdef CMP_STATS_EN
   logic [CNT_W-1:0] total_cnt;
   logic [CNT_W-1:0] taken_cnt;
`endif

   int errors_cnt = 0;
   int checks_cnt = 0;

   branch_cmp_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .rd1(rd1), .rd2(rd2), .cmp_op(cmp_op), .tag(tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_tag(out_tag)
`ifdef CMP_STATS_EN
      , .total_cnt(total_cnt), .taken_cnt(taken_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one compare with out_ready high, check 2-cycle latency, then drain it.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic exp);
      cmp_op    = op;
      rd1       = a;
      rd2       = b;
      tag       = t;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check({name, "_lat1"}, 32'(out_valid), 32'd0);
      step();
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check(name, 32'(out_taken), 32'(exp));
      check({name, "_tag"}, 32'(out_tag), 32'(t));
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int  next_t;
      int  exp_t;
      logic acc;
      logic cons;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      rd1 = 32'h0; rd2 = 32'h0; cmp_op = 3'b000; tag = 5'd0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_taken", 32'(out_taken), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Compare-mode table
      run_op("eq_same",     3'b000, 32'h0000_1234, 32'h0000_1234, 5'd7,  1'b1);
      run_op("eq_diff",     3'b000, 32'h0000_1234, 32'h0000_1235, 5'd8,  1'b0);
      run_op("ne_diff",     3'b001, 32'h0000_0001, 32'h0000_0002, 5'd9,  1'b1);
      run_op("lez_zero",    3'b010, 32'h0000_0000, 32'h0000_0005, 5'd10, 1'b1);
      run_op("lez_pos",     3'b010, 32'h0000_0005, 32'h0000_0000, 5'd11, 1'b0);
      run_op("gtz_min",     3'b011, 32'h8000_0000, 32'h0000_0000, 5'd12, 1'b0);
      run_op("gtz_one",     3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd13, 1'b1);
      run_op("ltz_min",     3'b100, 32'h8000_0000, 32'h0000_0000, 5'd14, 1'b1);
      run_op("gez_max",     3'b101, 32'h7FFF_FFFF, 32'h0000_0000, 5'd15, 1'b1);
      run_op("lts_neg1",    3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd16, 1'b1);
      run_op("ltu_neg1",    3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd17, 1'b0);
      run_op("lts_pos_neg", 3'b110, 32'h0000_0005, 32'hFFFF_FFFE, 5'd18, 1'b0);
      run_op("ltu_small",   3'b111, 32'h0000_0005, 32'hFFFF_FFFE, 5'd31, 1'b1);

      // Back-pressure: tags 1..4 streamed, consumer stalls for three cycles
      next_t = 1;
      exp_t  = 1;
      for (int cyc = 0; cyc < 40 && exp_t <= 4; cyc++) begin
         in_valid  = (next_t <= 4);
         tag       = 5'(next_t);
         cmp_op    = 3'b000;
         rd1       = 32'h55;
         rd2       = 32'h55;
         out_ready = !(cyc >= 2 && cyc <= 4);
         #1;
         acc  = in_valid && in_ready;
         cons = out_valid && out_ready;
         if (cyc == 2) begin
            check("bp_in_ready_drop", 32'(in_ready), 32'd0);
            check("bp_accepted_before_drop", 32'(next_t - 1), 32'd2);
         end
         if (out_valid) begin
            check("bp_tag_order", 32'(out_tag), 32'(exp_t));
         end
         step();
         if (acc) next_t++;
         if (cons) exp_t++;
      end
      in_valid = 1'b0;
      check("bp_all_delivered", 32'(exp_t), 32'd5);
      check("bp_drained", 32'(out_valid), 32'd0);

      // Flush with both stages full and a new request accepted in the same cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      cmp_op    = 3'b000;
      rd1       = 32'h1;
      rd2       = 32'h1;
      tag       = 5'd10;
      step();
      tag = 5'd11;
      step();
      check("fl_full_valid", 32'(out_valid), 32'd1);
      check("fl_full_tag", 32'(out_tag), 32'd10);
      check("fl_full_in_ready", 32'(in_ready), 32'd0);
      flush     = 1'b1;
      tag       = 5'd12;
      out_ready = 1'b1;
      #1;
      check("fl_cycle_in_ready", 32'(in_ready), 32'd1);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("fl_no_ghost", 32'(out_valid), 32'd0);
      end

`ifdef CMP_STATS_EN
      // Statistics: clear, then saturate the 2-bit counters
      reset = 1'b1;
      #2;
      reset = 1'b0;
      check("st_clr_total", 32'(total_cnt), 32'd0);
      check("st_clr_taken", 32'(taken_cnt), 32'd0);
      run_op("st_nt0", 3'b000, 32'h1, 32'h2, 5'd1, 1'b0);
      check("st_nt0_total", 32'(total_cnt), 32'd1);
      check("st_nt0_taken", 32'(taken_cnt), 32'd0);
      for (int i = 0; i < 5; i++) begin
         run_op("st_tk", 3'b001, 32'h1, 32'h2, 5'(i + 2), 1'b1);
      end
      check("st_sat_total", 32'(total_cnt), 32'd3);
      check("st_sat_taken", 32'(taken_cnt), 32'd3);
      run_op("st_nt1", 3'b000, 32'h3, 32'h4, 5'd9, 1'b0);
      check("st_hold_total", 32'(total_cnt), 32'd3);
      check("st_hold_taken", 32'(taken_cnt), 32'd3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("st_flush_keeps", 32'(total_cnt), 32'd3);
`endif

      // Asynchronous reset between edges with the pipeline full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      cmp_op    = 3'b000;
      rd1       = 32'h7;
      rd2       = 32'h7;
      tag       = 5'd20;
      step();
      tag = 5'd21;
      step();
      in_valid = 1'b0;
      check("ar_full_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_out_valid", 32'(out_valid), 32'd0);
      check("ar_in_ready", 32'(in_ready), 32'd1);
      check("ar_out_tag", 32'(out_tag), 32'd0);
`ifdef CMP_STATS_EN
      check("ar_total_cnt", 32'(total_cnt), 32'd0);
      check("ar_taken_cnt", 32'(taken_cnt), 32'd0);
`endif
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ar_dropped", 32'(out_valid), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
      $finish;
   end
endmodule

// File: doc/branch_cmp_pipe.md
BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (>=2).
REQ-002 SHALL have parameter: TAG_W, 5, width of the sideband tag carried with each compare.
REQ-003 SHALL have parameter: CNT_W, 16, width of the statistics counters.
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: flush  input  1  synchronous pipeline kill.
REQ-007 SHALL have port: in_valid  input  1  request present.
REQ-008 SHALL have port: in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-009 SHALL have port: rd1  input  WIDTH  first operand.
REQ-010 SHALL have port: rd2  input  WIDTH  second operand.
REQ-011 SHALL have port: cmp_op  input  3  compare mode.
REQ-012 SHALL have port: tag  input  TAG_W  sideband, returned unchanged.
REQ-013 SHALL have port: out_valid  output  1  result present.
REQ-014 SHALL have port: out_ready  input  1  consumer takes result when high with out_valid.
REQ-015 SHALL have port: out_taken  output  1  compare result.
REQ-016 SHALL have port: out_tag  output  TAG_W  tag of the result.
REQ-017 SHALL have ports (CMP_STATS_EN only): total_cnt  output  CNT_W  results consumed; taken_cnt  output  CNT_W  taken results consumed.

Function
REQ-018 cmp_op encoding SHALL be: 000 rd1==rd2; 001 rd1!=rd2; 010 rd1<=0 signed; 011 rd1>0 signed; 100 rd1<0 signed; 101 rd1>=0 signed; 110 rd1<rd2 signed; 111 rd1<rd2 unsigned; rd2 ignored for 010-101.
REQ-019 Pipeline SHALL be two stages: S1 registers rd1, rd2, cmp_op, tag; S2 registers computed taken bit and tag; each stage has its own valid bit.
REQ-020 S2 SHALL load from S1 when S1 valid and (S2 empty or out_valid&&out_ready); S1 SHALL load on in_valid&&in_ready.
REQ-021 in_ready SHALL equal !s1_valid || (S1 moving to S2 this cycle); combinational, no dependence on in_valid.
REQ-022 Latency SHALL be 2 cycles from acceptance to out_valid with out_ready held high; throughput one result per cycle.
REQ-023 out_valid/out_taken/out_tag SHALL hold stable while out_valid && !out_ready; no result lost or duplicated under any back-pressure pattern.
REQ-024 flush SHALL clear both valid bits at the next edge; a request accepted in the flush cycle SHALL be discarded; flush has priority over all loads.
REQ-025 Signed compares SHALL use two's complement on full WIDTH; no result wider than 1 bit.

Reset
REQ-026 On reset: s1_valid=0, s2_valid=0, out_valid=0, out_taken=0, out_tag=0, counters=0; in_ready=1 while reset deasserted and pipeline empty.
REQ-027 Reset asserted mid-operation SHALL drop all in-flight requests immediately, without waiting for a clock edge.

Configuration
REQ-028 Macro CMP_STATS_EN defined: total_cnt increments on each out_valid&&out_ready; taken_cnt increments when additionally out_taken=1; both saturate at all-ones; cleared by reset only, not by flush.
REQ-029 CMP_STATS_EN undefined: total_cnt/taken_cnt ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 WIDTH=32, out_ready=1, op 000 rd1=rd2=0x1234 at cycle 0 -> out_valid=1, out_taken=1 at cycle 2, out_tag matches.
REQ-031 op 110 rd1=0xFFFFFFFF rd2=1 -> taken=1; op 111 same operands -> taken=0; op 010 rd1=0 -> 1; op 011 rd1=0x80000000 -> 0.
REQ-032 Back-to-back 4 requests (tags 1..4) with out_ready low 3 cycles -> in_ready drops after 2 accepted; tags emerge 1,2,3,4 in order, none lost.
REQ-033 flush asserted with both stages full and in_valid high -> next cycle out_valid=0, s1 empty, in_ready=1; flushed tags never appear.
REQ-034 reset pulsed asynchronously between edges with pipeline full -> out_valid=0 immediately; counters=0 (CMP_STATS_EN).
REQ-035 CMP_STATS_EN, CNT_W=2, 5 taken results consumed -> total_cnt=3, taken_cnt=3 (saturated); 1 not-taken -> unchanged.
